// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that streams one 4-bit nibble per
// clock through a 4-bit carry-lookahead slice, chaining the slice carry in a
// register. Operands are accepted on an in_valid/in_ready handshake and the
// full-width result is returned on an out_valid/out_ready handshake.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed 'overflow' port.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carryout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Parameter sanity: whole nibbles and at least two of them.
  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] y_q;
  logic             cout_q;

  logic             accept;
  logic             consume;
  logic             last_nibble;

  // Slice operands and results
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_g;
  logic [3:0]       slice_p;
  logic [4:0]       slice_c;
  logic [3:0]       slice_sum;

`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid && in_ready;
  assign consume     = out_valid && out_ready;
  assign last_nibble = (idx_q == IW'(NIBBLES - 1));

  assign Y        = y_q;
  assign carryout = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign overflow = ovf_q;
`endif

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice: all carries computed from g/p and carry-in.
  always_comb begin
    slice_g    = nib_a & nib_b;
    slice_p    = nib_a ^ nib_b;
    slice_c[0] = c_q;
    slice_c[1] = slice_g[0]
               | (slice_p[0] & c_q);
    slice_c[2] = slice_g[1]
               | (slice_p[1] & slice_g[0])
               | (slice_p[1] & slice_p[0] & c_q);
    slice_c[3] = slice_g[2]
               | (slice_p[2] & slice_g[1])
               | (slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[2] & slice_p[1] & slice_p[0] & c_q);
    slice_c[4] = slice_g[3]
               | (slice_p[3] & slice_g[2])
               | (slice_p[3] & slice_p[2] & slice_g[1])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & c_q);
    slice_sum  = slice_p ^ slice_c[3:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept in IDLE, step nibbles in RUN, hand off in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (consume) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture: only the IDLE handshake may load the operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == IDLE && accept) begin
      a_q <= A;
      b_q <= B;
    end
  end

  // Carry chain register and nibble index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q   <= 1'b0;
      idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            c_q   <= carryin;
            idx_q <= '0;
          end
        end
        RUN: begin
          c_q <= slice_c[4];
          if (!last_nibble) begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          c_q   <= c_q;
          idx_q <= idx_q;
        end
      endcase
    end
  end

  // Result register: each RUN cycle writes one sum nibble; held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        if (idx_q == IW'(i)) begin
          y_q[4*i +: 4] <= slice_sum;
        end
      end
    end
  end

  // Carry-out register: captured from the slice on the most-significant nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
    end else if (state_q == RUN && last_nibble) begin
      cout_q <= slice_c[4];
    end
  end

`ifdef OVERFLOW_FLAG_EN
  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_nibble) begin
      ovf_q <= slice_c[3] ^ slice_c[4];
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16). The stimulus process
// pushes the expected result when operands are accepted; a monitor pops and
// compares every time a result is handed off.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         carryin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic         carryout;
`ifdef OVERFLOW_FLAG_EN
  logic         overflow;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .carryin   (carryin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .carryout  (carryout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   ready_rand  = 1'b0;
  logic ready_force = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // out_ready driver: forced value or random gaps, applied just after each edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got Y=0x%0h, required no result", Y);
        end else begin
          e = q.pop_front();
          chk("result_y", 32'(Y), 32'(e.y));
          chk("result_carryout", 32'(carryout), 32'(e.c));
`ifdef OVERFLOW_FLAG_EN
          chk("result_overflow", 32'(overflow), 32'(e.ov));
`endif
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input bit push, input logic [W-1:0] ey, input logic ec, input logic eov);
    bit   accepted;
    exp_t e;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    A = a;
    B = b;
    carryin = cin;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
    end else if (push) begin
      e.y = ey;
      e.c = ec;
      e.ov = eov;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    bit          seen;
    logic [W-1:0] ra, rb;
    logic        rc;
    logic [W:0]  s;
    logic        rov;

    rst_n = 1'b0;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    carryin = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_y", 32'(Y), 32'h0000);
    chk("reset_carryout", 32'(carryout), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("reset_overflow", 32'(overflow), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic add with latency measurement, consumer stalled
    ready_force = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    chk("latency_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'd4);

    // Backpressure: 10 stalled cycles with ignored in_valid
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      A = 16'hFFFF;
      B = 16'hFFFF;
      carryin = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_y", 32'(Y), 32'h5555);
      chk("bp_carryout", 32'(carryout), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_force = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    @(negedge clk);
    chk("post_consume_in_ready", 32'(in_ready), 32'd1);
    chk("post_consume_out_valid", 32'(out_valid), 32'd0);
    chk("idle_holds_y", 32'(Y), 32'h5555);
    chk("post_consume_pending", 32'(q.size()), 32'd0);

    // Full ripple and signed overflow
    ready_force = 1'b1;
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    send(16'hF0F0, 16'h0F0F, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    drain();

    // Reset in the middle of RUN
    send(16'hABCD, 16'h1111, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_y", 32'(Y), 32'h0000);
    chk("midrun_rst_carryout", 32'(carryout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrun_no_result", 32'(out_valid), 32'd0);
    end
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    drain();

    // Back-to-back random traffic with random consumer gaps
    ready_rand = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      s = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      rov = (ra[W-1] == rb[W-1]) && (s[W-1] != ra[W-1]);
      send(ra, rb, rc, 1'b1, s[W-1:0], s[W], rov);
    end
    drain();
    ready_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
